// File: rtl/verdict_pkg.sv
// Shared types and constants for the verdict stream collector: the buffered
// record, the serializer states and the header word layout.
package verdict_pkg;

  localparam int VERDICT_DATA_W = 64;
  localparam int TS_MAX_W       = VERDICT_DATA_W - 2;

  // Header word: mask in the top two bits, zero-extended timestamp from bit 0.
  localparam int MASK_HI = VERDICT_DATA_W - 1;
  localparam int MASK_LO = VERDICT_DATA_W - 2;
  localparam int TS_LO   = 0;

  typedef struct packed {
    logic [TS_MAX_W-1:0]       ts;
    logic [1:0]                mask;
    logic [VERDICT_DATA_W-1:0] val0;
    logic [VERDICT_DATA_W-1:0] val1;
  } verdict_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_D0,
    ST_D1
  } ser_state_e;

  function automatic bit depth_legal(int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit ts_w_legal(int ts_w, int data_w);
    return (data_w == VERDICT_DATA_W) && (ts_w >= 1) && (ts_w <= data_w - 2);
  endfunction

endpackage

// File: rtl/verdict_fifo.sv
// Synchronous record FIFO; a push is accepted while full when a pop happens on
// the same edge, since the read slot is freed as the write lands.
module verdict_fifo
  import verdict_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  verdict_rec_t wr_rec_i,
  input  logic         pop_i,
  output verdict_rec_t rd_rec_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  verdict_rec_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);
  assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  assign rd_rec_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: non-blocking assignments for all state, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec_i;
  end

endmodule

// File: rtl/verdict_stream_collector.sv
// Timestamps active monitor outputs, buffers them as records and serializes
// each record as header + one word per active output over valid/ready.
module verdict_stream_collector
  import verdict_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] output_0,
  input  logic              output_0_aktv,
  input  logic [DATA_W-1:0] output_1,
  input  logic              output_1_aktv,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  if (!ts_w_legal(TS_W, DATA_W) || !depth_legal(DEPTH)) begin : g_illegal_params
    $error("verdict_stream_collector: illegal DATA_W/TS_W/DEPTH combination");
  end

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  verdict_rec_t      rec_q, rec_d;
  verdict_rec_t      sample_rec, fifo_rd_rec;
  ser_state_e        state_q, state_d;
  logic              sample, drop, fifo_pop, fifo_full, fifo_empty, rec_end;

  assign sample     = en && (output_0_aktv || output_1_aktv);
  assign drop       = sample && fifo_full && !fifo_pop;
  assign ts_d       = en ? ts_q + TS_W'(1) : ts_q;
  assign overflow_d = overflow_q || drop;
  assign drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + DROP_W'(1) : drop_cnt_q;
  assign rec_d      = fifo_pop ? fifo_rd_rec : rec_q;

  always_comb begin
    sample_rec               = '0;
    sample_rec.ts[TS_W-1:0]  = ts_q;
    sample_rec.mask          = {output_1_aktv, output_0_aktv};
    sample_rec.val0          = output_0;
    sample_rec.val1          = output_1;
  end

  verdict_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push_i   (sample),
    .wr_rec_i (sample_rec),
    .pop_i    (fifo_pop),
    .rd_rec_o (fifo_rd_rec),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q       <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
      rec_q      <= '0;
      state_q    <= ST_IDLE;
    end else begin
      ts_q       <= ts_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
      rec_q      <= rec_d;
      state_q    <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    rec_end  = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = ST_HDR;
      end
      ST_HDR:  if (m_ready) state_d = rec_q.mask[0] ? ST_D0 : ST_D1;
      ST_D0:   if (m_ready) begin
        if (rec_q.mask[1]) state_d = ST_D1;
        else               rec_end = 1'b1;
      end
      ST_D1:   if (m_ready) rec_end = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    // Chain straight into the next record's header so records stream without a bubble.
    if (rec_end) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = ST_HDR;
      end else begin
        state_d  = ST_IDLE;
      end
    end
  end

  // Outputs derive only from registered state, so they hold while stalled.
  always_comb begin
    m_valid = (state_q != ST_IDLE);
    m_data  = '0;
    m_last  = 1'b0;
    case (state_q)
      ST_HDR: begin
        m_data[MASK_HI:MASK_LO]  = rec_q.mask;
        m_data[TS_MAX_W-1:TS_LO] = rec_q.ts;
      end
      ST_D0: begin
        m_data = rec_q.val0;
        m_last = !rec_q.mask[1];
      end
      ST_D1: begin
        m_data = rec_q.val1;
        m_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_verdict_stream_collector.sv
// Scoreboard bench: stimulus queues expected stream words, per-DUT monitors
// pop and compare on every handshake and check stability while stalled.
module tb_verdict_stream_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en, a0, a1, m_ready;
  logic [63:0] o0, o1;
  logic        m_valid, m_last, overflow;
  logic [63:0] m_data;
  logic [15:0] drop_cnt;

  logic        w_en, w_a0, w_a1, w_ready;
  logic [63:0] w_o0, w_o1;
  logic        w_valid, w_last, w_overflow;
  logic [63:0] w_data;
  logic [15:0] w_drop_cnt;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } word_t;

  word_t exp_q[$];
  word_t wexp_q[$];
  word_t mon_w, wmon_w;
  int    vectors     = 0;
  int    miscompares = 0;
  int    ts_m        = 0;
  int    frozen_ts   = 0;
  int    n           = 0;

  logic [63:0] prev_data;
  logic        prev_last;
  logic        prev_stall = 1'b0;

  verdict_stream_collector dut (
    .clk(clk), .rst(rst), .en(en),
    .output_0(o0), .output_0_aktv(a0), .output_1(o1), .output_1_aktv(a1),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  verdict_stream_collector #(.TS_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .en(w_en),
    .output_0(w_o0), .output_0_aktv(w_a0), .output_1(w_o1), .output_1_aktv(w_a1),
    .m_valid(w_valid), .m_ready(w_ready), .m_data(w_data), .m_last(w_last),
    .overflow(w_overflow), .drop_cnt(w_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [1:0] m, input int ts);
    return {m, 30'd0, 32'(ts)};
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    exp_q.push_back(w);
  endtask

  task automatic tick;
    logic e;
    e = en;
    @(posedge clk);
    #1;
    if (e) ts_m++;
  endtask

  task automatic wait_drain;
    int k;
    k = 0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0 || m_valid || w_valid) && k < 200) begin
      tick();
      k++;
    end
    check("drain_in_time", 64'(k < 200), 64'd1);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    wexp_q.delete();
    #1;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_data", m_data, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    ts_m = 0;
  endtask

  // Main DUT monitor: compares each accepted word and holds stalled words steady.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", m_data, prev_data);
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h, expected no word", m_data);
        end else begin
          mon_w = exp_q.pop_front();
          check("word_data", m_data, mon_w.data);
          check("word_last", 64'(m_last), 64'(mon_w.last));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  always @(negedge clk) begin
    if (rst && w_valid && w_ready) begin
      if (wexp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wrap_word: got %h, expected no word", w_data);
      end else begin
        wmon_w = wexp_q.pop_front();
        check("wrap_data", w_data, wmon_w.data);
        check("wrap_last", 64'(w_last), 64'(wmon_w.last));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    en = 0; a0 = 0; a1 = 0; o0 = '0; o1 = '0; m_ready = 1;
    w_en = 0; w_a0 = 0; w_a1 = 0; w_o0 = '0; w_o1 = '0; w_ready = 1;
    #2;
    check("por_valid", 64'(m_valid), 64'd0);
    check("por_data", m_data, 64'd0);
    check("por_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single output_0 event at ts=100.
    en = 1;
    repeat (100) tick();
    push_exp(64'h4000_0000_0000_0064, 1'b0);
    push_exp(64'd5, 1'b1);
    o0 = 64'd5; a0 = 1;
    tick();
    a0 = 0;
    wait_drain();
    check("single_drop_cnt", 64'(drop_cnt), 64'd0);
    check("single_overflow", 64'(overflow), 64'd0);

    // Dual event at ts=20, negative output_1.
    do_reset();
    en = 1;
    repeat (20) tick();
    push_exp(64'hC000_0000_0000_0014, 1'b0);
    push_exp(64'd7, 1'b0);
    push_exp(64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    o0 = 64'd7; o1 = 64'hFFFF_FFFF_FFFF_FFFD; a0 = 1; a1 = 1;
    tick();
    a0 = 0; a1 = 0;
    wait_drain();

    // Backpressure: one record parked in the serializer, then 10 events fill 8 slots and drop 2.
    m_ready = 0;
    push_exp(mk_hdr(2'b01, ts_m), 1'b0);
    push_exp(64'd100, 1'b1);
    o0 = 64'd100; a0 = 1;
    tick();
    a0 = 0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      o0 = 64'(200 + i); a0 = 1;
      if (i < 8) begin
        push_exp(mk_hdr(2'b01, ts_m), 1'b0);
        push_exp(64'(200 + i), 1'b1);
      end
      tick();
    end
    a0 = 0;
    tick();
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    m_ready = 1;
    n = 0;
    while (m_valid && n < 100) begin
      tick();
      n++;
    end
    check("drain_no_bubble_cycles", 64'(n), 64'd18);
    check("drain_all_words", 64'(exp_q.size()), 64'd0);

    // en gating: queued record drains with en=0; aktv ignored; ts frozen.
    m_ready = 0;
    push_exp(mk_hdr(2'b01, ts_m), 1'b0);
    push_exp(64'h33, 1'b1);
    o0 = 64'h33; a0 = 1;
    tick();
    en = 0;
    frozen_ts = ts_m;
    o0 = 64'd1; o1 = 64'd2; a0 = 1; a1 = 1;
    repeat (5) tick();
    a0 = 0; a1 = 0;
    m_ready = 1;
    wait_drain();
    check("gate_drop_cnt", 64'(drop_cnt), 64'd2);
    en = 1;
    push_exp(mk_hdr(2'b10, frozen_ts), 1'b0);
    push_exp(64'h44, 1'b1);
    o1 = 64'h44; a1 = 1;
    tick();
    a1 = 0;
    wait_drain();

    // Reset while the serializer is in D0 with a second record still buffered.
    m_ready = 0;
    push_exp(mk_hdr(2'b11, ts_m), 1'b0);
    o0 = 64'h11; o1 = 64'h22; a0 = 1; a1 = 1;
    tick();
    a1 = 0; o0 = 64'h55;
    tick();
    a0 = 0;
    tick();
    m_ready = 1;
    tick();
    m_ready = 0;
    rst = 0;
    exp_q.delete();
    #1;
    check("midrec_valid", 64'(m_valid), 64'd0);
    check("midrec_last", 64'(m_last), 64'd0);
    check("midrec_data", m_data, 64'd0);
    check("midrec_overflow", 64'(overflow), 64'd0);
    @(posedge clk);
    #1;
    rst = 1;
    ts_m = 0;
    m_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", 64'(m_valid), 64'd0);
    end
    push_exp(64'h4000_0000_0000_0003, 1'b0);
    push_exp(64'h66, 1'b1);
    o0 = 64'h66; a0 = 1;
    tick();
    a0 = 0;
    wait_drain();

    // Timestamp wrap on the 4-bit instance: 17 enabled edges -> ts=1.
    w_en = 1;
    repeat (17) tick();
    mon_w.data = 64'h4000_0000_0000_0001; mon_w.last = 1'b0;
    wexp_q.push_back(mon_w);
    mon_w.data = 64'd9; mon_w.last = 1'b1;
    wexp_q.push_back(mon_w);
    w_o0 = 64'd9; w_a0 = 1;
    tick();
    w_a0 = 0;
    wait_drain();
    check("wrap_drop_cnt", 64'(w_drop_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/verdict_stream_collector.md
Name: verdict_stream_collector

Overview:
- Downstream consumer of the generated monitor `topEntity`.
- Samples the monitor's two output streams (value plus activation flag) on every enabled cycle in which at least one is active.
- Tags each sample with a free-running cycle timestamp, buffers it, and drains it as a variable-length word stream over a valid/ready interface to a host or logger.
- Replaces ad-hoc bench `$display` checks with a synthesizable verdict path.

Parameters:
- DATA_W, 64, width of each monitor output value and of a stream word.
- TS_W, 32, timestamp counter width; must satisfy TS_W <= DATA_W-2.
- DEPTH, 8, record FIFO depth; power of two, >= 2.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous and active-low, as decided.
- en  in  1  same enable as the monitor; gates sampling and timestamp advance.
- output_0  in  DATA_W  monitor output 0 value (signed, passed through unmodified).
- output_0_aktv  in  1  output 0 produced this cycle.
- output_1  in  DATA_W  monitor output 1 value.
- output_1_aktv  in  1  output 1 produced this cycle.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts word.
- m_data  out  DATA_W  stream word.
- m_last  out  1  final word of the current record.
- overflow  out  1  sticky; a record was dropped.
- drop_cnt  out  DROP_W  records dropped, saturating.

Behaviour:
- Reset (rst=0, asynchronous): m_valid=0, m_last=0, m_data=0, overflow=0, drop_cnt=0, timestamp=0, FIFO empty, FSM=IDLE. Takes effect immediately, including mid-record; the partially sent record is discarded.
- Timestamp: increments by 1 on every edge with en=1; holds when en=0; wraps modulo 2^TS_W.
- Sampling: at an edge with en=1 and mask={output_1_aktv,output_0_aktv} != 0, form a record {ts, mask, output_0, output_1}.
  - ts is the counter value before that edge's increment.
  - mask=0 is never recorded. en=0 suppresses sampling regardless of aktv.
- Push rule: the record is written if the FIFO is not full, or if a pop occurs on the same edge.
  - Otherwise the record is dropped: overflow is set and drop_cnt increments, saturating at all-ones.
- FSM states: IDLE, HDR, D0, D1.
  - IDLE: if FIFO non-empty, pop into the record register and go to HDR. m_valid=0.
  - HDR: m_data = {mask[1:0], zero pad, ts (low TS_W bits)}. m_valid=1, m_last=0. On handshake, go to D0 if mask[0], else D1.
  - D0: m_data=output_0 value, m_last = !mask[1]. On handshake, go to D1 if mask[1], else the end-of-record step.
  - D1: m_data=output_1 value, m_last=1. On handshake, take the end-of-record step.
  - End-of-record step: if FIFO non-empty, pop and go directly to HDR (back-to-back records, no bubble); else go to IDLE.
- Stream rules:
  - m_data, m_last and m_valid stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake, except on reset.
- Latency, empty buffer: sample at edge E, FIFO write at E, pop at E+1, header valid after E+1. Minimum 2 edges.
- Throughput: one word per cycle under m_ready=1. A two-output record takes 3 cycles, so sustained full-rate dual activity overflows by design.
- Draining continues while en=0.

Decomposition:
- Package verdict_pkg:
  - record struct (ts, mask, val0, val1);
  - FSM state enum;
  - header field positions (MASK_HI=DATA_W-1, MASK_LO=DATA_W-2, TS_LO=0);
  - DEPTH/TS_W legality checks.
- Sub-module verdict_fifo: synchronous FIFO of records with full/empty, same-edge push+pop allowed when full, async active-low reset.
- The collector itself holds the timestamp counter, drop logic and serializer FSM.

Test Plan:
- Single event: reset, 100 enabled cycles, then output_0=5 with aktv0=1 for one cycle, m_ready=1 → header {2'b01, ts=100}, then word 5 with m_last=1. drop_cnt=0.
- Dual event: output_0=7, output_1=-3, both aktv, at ts=20 → 3 words: header {2'b11, 20}, 7, then 0xFFFF_FFFF_FFFF_FFFD with m_last only on the third word.
- Backpressure and overflow: m_ready=0, 10 single-output events on consecutive enabled cycles → 8 stored, overflow=1, drop_cnt=2. Release m_ready → 8 records emitted in order with no bubble between them; m_data is stable during stall.
- en gating: aktv pulses while en=0 → no records and timestamp frozen. A record already queued still drains.
- Reset mid-record: assert rst during D0 → m_valid=0 immediately. After release, FIFO is empty, timestamp is 0, and the next event at ts=3 emits a correct header.
- Wrap: TS_W=4, event after 17 enabled cycles → header ts=1.
